// File: rtl/melody_sequencer.sv
// melody_sequencer: debounces play/stop keys, walks a 48-entry melody ROM and
// hands the buzzer tone generator a half-period count plus an enable.
// Optional macro LOOP_PLAYBACK_EN: after the last note, restart at entry 0
// instead of returning to IDLE.
module melody_sequencer #(
    parameter int unsigned UNIT_CYCLES     = 5_000_000,
    parameter int unsigned GAP_CYCLES      = 500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MELODY_LEN      = 48
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_play,
    input  logic        key_stop,
    output logic [31:0] tone_half_period,
    output logic        tone_en,
    output logic [5:0]  note_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

    localparam logic [31:0] UNIT_W   = 32'(UNIT_CYCLES);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] DB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]  LAST_IDX = 6'(MELODY_LEN - 1);

    // Melody ROM {dur, code}: six 8-entry phrases, each 7 notes then a long rest.
    function automatic logic [7:0] rom_entry(input logic [5:0] idx);
        logic [3:0] code;
        code = 4'd0;
        if (idx[2:0] == 3'd7) return 8'h80;
        case (idx[5:3])
            3'd0, 3'd4: case (idx[2:0])      // C C G G A A G
                3'd0, 3'd1: code = 4'd1;
                3'd2, 3'd3: code = 4'd5;
                3'd4, 3'd5: code = 4'd6;
                default:    code = 4'd5;
            endcase
            3'd1, 3'd5: case (idx[2:0])      // F F E E D D C
                3'd0, 3'd1: code = 4'd4;
                3'd2, 3'd3: code = 4'd3;
                3'd4, 3'd5: code = 4'd2;
                default:    code = 4'd1;
            endcase
            3'd2, 3'd3: case (idx[2:0])      // G G F F E E D
                3'd0, 3'd1: code = 4'd5;
                3'd2, 3'd3: code = 4'd4;
                3'd4, 3'd5: code = 4'd3;
                default:    code = 4'd2;
            endcase
            default: code = 4'd0;
        endcase
        return {4'd1, code};
    endfunction

    // Half-period for C4..B4 at 100 MHz; anything else is silence.
    function automatic logic [31:0] half_period(input logic [3:0] code);
        case (code)
            4'd1:    return 32'd191113;
            4'd2:    return 32'd170262;
            4'd3:    return 32'd151686;
            4'd4:    return 32'd143173;
            4'd5:    return 32'd127553;
            4'd6:    return 32'd113636;
            4'd7:    return 32'd101239;
            default: return 32'd0;
        endcase
    endfunction

    // Key path: bit 0 = play, bit 1 = stop.
    logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d, rise;
    logic [1:0][31:0] db_cnt_q, db_cnt_d;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] thp_q, thp_d;
    logic        tone_en_q, tone_en_d, busy_q, busy_d, done_q, done_d;

    logic        play_edge, stop_edge;
    logic [7:0]  cur_entry, next_entry;
    logic [3:0]  dur_eff;
    logic [31:0] note_last;

    // Synchronise both keys and accept a new level after enough equal samples.
    always_comb begin
        sync1_d  = {key_stop, key_play};
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        rise     = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync2_q[k] == stable_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DB_LAST) begin
                stable_d[k] = sync2_q[k];
                db_cnt_d[k] = '0;
                rise[k]     = sync2_q[k];
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + 32'd1;
            end
        end
    end

    assign play_edge = rise[0];
    assign stop_edge = rise[1];

    assign cur_entry = rom_entry(idx_q);
    assign dur_eff   = (cur_entry[7:4] == 4'd0) ? 4'd1 : cur_entry[7:4];
    assign note_last = ({28'd0, dur_eff} * UNIT_W) - 32'd1;

    // Sequencer next state; outputs are precomputed from the next state so
    // they only move on state or note transitions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (play_edge && !stop_edge) begin
                    state_d = S_NOTE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_NOTE: begin
                if (stop_edge) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == note_last) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (stop_edge) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_NOTE;
                    end else begin
                        done_d = 1'b1;
                        idx_d  = '0;
`ifdef LOOP_PLAYBACK_EN
                        state_d = S_NOTE;
`else
                        state_d = S_IDLE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        next_entry = rom_entry(idx_d);
        busy_d     = (state_d != S_IDLE);
        tone_en_d  = (state_d == S_NOTE) && (next_entry[3:0] >= 4'd1) && (next_entry[3:0] <= 4'd7);
        thp_d      = tone_en_d ? half_period(next_entry[3:0]) : 32'd0;
    end

    // State, debounce and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            db_cnt_q  <= '0;
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            thp_q     <= '0;
            tone_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            thp_q     <= thp_d;
            tone_en_q <= tone_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tone_half_period = thp_q;
    assign tone_en          = tone_en_q;
    assign note_idx         = idx_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with short timing parameters
// (unit 4, gap 2, debounce 3). Every note is 6 cycles, every rest 34.
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_play, key_stop;
    logic [31:0] tone_half_period;
    logic        tone_en, busy, done;
    logic [5:0]  note_idx;

    int tests = 0;
    int fails = 0;
    int n;
    logic seen_busy, seen_done;
    logic [5:0] prev_idx;

    melody_sequencer #(
        .UNIT_CYCLES(4), .GAP_CYCLES(2), .DEBOUNCE_CYCLES(3), .MELODY_LEN(48)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_play(key_play), .key_stop(key_stop),
        .tone_half_period(tone_half_period), .tone_en(tone_en),
        .note_idx(note_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge.
    task automatic step(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
            if (done) seen_done = 1'b1;
        end
    endtask

    // Hold play until the sequencer starts (bounded), then release.
    task automatic start_play(output int cycles);
        cycles = 0;
        key_play = 1'b1;
        while (!busy && cycles < 20) begin
            step(1);
            cycles++;
        end
        key_play = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; key_play = 1'b0; key_stop = 1'b0;
        seen_busy = 1'b0; seen_done = 1'b0;

        // Reset with keys toggling
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            key_play = ~key_play;
            key_stop = ~key_stop;
        end
        step(1);
        chk("rst_thp", tone_half_period, 0);
        chk("rst_tone_en", {31'd0, tone_en}, 0);
        chk("rst_idx", {26'd0, note_idx}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        key_play = 1'b0; key_stop = 1'b0; rst_n = 1'b1;
        step(8);

        // Bounce rejection: two 2-cycle pulses never qualify
        seen_busy = 1'b0;
        key_play = 1'b1; step(2);
        key_play = 1'b0; step(1);
        key_play = 1'b1; step(2);
        key_play = 1'b0; step(6);
        chk("bounce_busy", {31'd0, seen_busy}, 0);

        // Held play starts entry 0 (C4): 2 sync + 3 debounce cycles
        start_play(n);
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_latency", n, 5);
        chk("start_tone_en", {31'd0, tone_en}, 1);
        chk("start_thp", tone_half_period, 191113);
        chk("start_idx", {26'd0, note_idx}, 0);

        // Note/gap timing
        step(3);
        chk("n0_last_tone", {31'd0, tone_en}, 1);
        step(1);
        chk("gap0_tone_en", {31'd0, tone_en}, 0);
        chk("gap0_thp", tone_half_period, 0);
        chk("gap0_busy", {31'd0, busy}, 1);
        step(1);
        chk("gap0b_tone_en", {31'd0, tone_en}, 0);
        step(1);
        chk("n1_idx", {26'd0, note_idx}, 1);
        chk("n1_thp", tone_half_period, 191113);
        chk("n1_tone_en", {31'd0, tone_en}, 1);

        // Play edge while busy at entry 5 is ignored
        step(24);
        chk("n5_idx", {26'd0, note_idx}, 5);
        key_play = 1'b1; step(5);
        key_play = 1'b0; step(1);
        chk("n6_idx", {26'd0, note_idx}, 6);
        chk("n6_thp", tone_half_period, 127553);

        // Entry 7: rest of 8 units plus gap
        step(6);
        chk("n7_idx", {26'd0, note_idx}, 7);
        chk("n7_tone_en", {31'd0, tone_en}, 0);
        chk("n7_busy", {31'd0, busy}, 1);
        step(33);
        chk("n7_end_idx", {26'd0, note_idx}, 7);
        chk("n7_end_tone_en", {31'd0, tone_en}, 0);
        step(1);
        chk("n8_idx", {26'd0, note_idx}, 8);
        chk("n8_thp", tone_half_period, 143173);

        // Stop accepted in the middle of entry 10
        step(9);
        key_stop = 1'b1;
        seen_done = 1'b0;
        n = 0;
        prev_idx = note_idx;
        while (busy && n < 15) begin
            prev_idx = note_idx;
            step(1);
            n++;
        end
        chk("stop_busy", {31'd0, busy}, 0);
        chk("stop_prev_idx", {26'd0, prev_idx}, 10);
        chk("stop_tone_en", {31'd0, tone_en}, 0);
        chk("stop_thp", tone_half_period, 0);
        chk("stop_idx", {26'd0, note_idx}, 0);
        key_stop = 1'b0;
        step(8);
        chk("stop_no_done", {31'd0, seen_done}, 0);

        // Simultaneous play+stop from IDLE stays IDLE
        seen_busy = 1'b0;
        key_play = 1'b1; key_stop = 1'b1;
        step(8);
        key_play = 1'b0; key_stop = 1'b0;
        step(8);
        chk("both_keys_busy", {31'd0, seen_busy}, 0);

        // Full pass: 42 notes * 6 + 6 rests * 34 = 456 cycles
        start_play(n);
        chk("full_start_busy", {31'd0, busy}, 1);
        n = 0;
        prev_idx = note_idx;
        while (!done && n < 600) begin
            prev_idx = note_idx;
            step(1);
            n++;
        end
        chk("done_seen", {31'd0, done}, 1);
        chk("done_cycle", n, 456);
        chk("done_prev_idx", {26'd0, prev_idx}, 47);
        chk("done_idx", {26'd0, note_idx}, 0);
`ifdef LOOP_PLAYBACK_EN
        chk("loop_busy", {31'd0, busy}, 1);
        chk("loop_tone_en", {31'd0, tone_en}, 1);
`else
        chk("end_busy", {31'd0, busy}, 0);
        chk("end_tone_en", {31'd0, tone_en}, 0);
`endif
        step(1);
        chk("done_pulse_len", {31'd0, done}, 0);

        // Reset mid-note
        if (!busy) start_play(n);
        step(2);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_tone_en", {31'd0, tone_en}, 0);
        chk("midrst_thp", tone_half_period, 0);
        chk("midrst_idx", {26'd0, note_idx}, 0);
        rst_n = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
